// File: rtl/regfile_wb_sequencer.sv
// Serialises Y86-64 write-back (dstE/valE, dstM/valM) onto the single register-file write port,
// with a per-register pending-write scoreboard for decode hazards. Optional macro: WB_FORWARD_EN.
module regfile_wb_sequencer #(
  parameter int NREGS  = 15,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 64,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic              wb_halt,
  input  logic [ADDR_W-1:0] wb_dstE,
  input  logic [DATA_W-1:0] wb_valE,
  input  logic [ADDR_W-1:0] wb_dstM,
  input  logic [DATA_W-1:0] wb_valM,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rd_srcA,
  input  logic [ADDR_W-1:0] rd_srcB,
  output logic              hazA,
  output logic              hazB,
`ifdef WB_FORWARD_EN
  output logic              fwdA_valid,
  output logic [DATA_W-1:0] fwdA_data,
  output logic              fwdB_valid,
  output logic [DATA_W-1:0] fwdB_data,
`endif
  output logic              halted,
  output logic [1:0]        dbg_state
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [ADDR_W-1:0] NONE = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_HALT = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, e_slot, m_slot;
  logic [ADDR_W-1:0] q_addr_q [QDEPTH];
  logic [DATA_W-1:0] q_data_q [QDEPTH];
  logic [CW-1:0]     cnt_q [NREGS];
  logic [CW-1:0]     cnt_d [NREGS];
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              accept, push_e, push_m, deq, baseA, baseB;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic src_pending(input logic [ADDR_W-1:0] s, input logic [CW-1:0] c);
    return (s != NONE) && (int'(s) < NREGS) && (c != '0);
  endfunction

  // Ready depends only on registered state so there is no valid->ready path.
  // Valid/ready: a request transfers on a rising edge where wb_valid && wb_ready.
  assign wb_ready  = (state_q == S_RUN) && (int'(count_q) <= QDEPTH - 2);
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign halted    = (state_q == S_HALT);
  assign dbg_state = state_q;
  assign baseA     = src_pending(rd_srcA, cnt_q[rd_srcA]);
  assign baseB     = src_pending(rd_srcB, cnt_q[rd_srcB]);

  always_comb begin
    accept   = wb_valid && wb_ready;
    push_e   = accept && !wb_halt && (wb_dstE != NONE);
    push_m   = accept && !wb_halt && (wb_dstM != NONE);
    deq      = (count_q != '0);
    e_slot   = wr_ptr_q;
    m_slot   = push_e ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push_e) wr_ptr_d = ptr_inc(wr_ptr_d);
    if (push_m) wr_ptr_d = ptr_inc(wr_ptr_d);
    rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push_e) + CW'(push_m) - CW'(deq);
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (push_e && wb_dstE == ADDR_W'(r)) cnt_d[r] = cnt_d[r] + CW'(1);
      if (push_m && wb_dstM == ADDR_W'(r)) cnt_d[r] = cnt_d[r] + CW'(1);
      if (deq && q_addr_q[rd_ptr_q] == ADDR_W'(r)) cnt_d[r] = cnt_d[r] - CW'(1);
    end
    state_d = state_q;
    case (state_q)
      S_RUN:   if (accept && wb_halt) state_d = S_DRAIN;
      S_DRAIN: if (count_d == '0) state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= NONE;
      rf_wdata_q <= '0;
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      rf_we_q  <= deq;
      if (deq) begin
        rf_waddr_q <= q_addr_q[rd_ptr_q];
        rf_wdata_q <= q_data_q[rd_ptr_q];
      end
      // E lands before M so that valM is the surviving value when both target one register.
      if (push_e) begin
        q_addr_q[e_slot] <= wb_dstE;
        q_data_q[e_slot] <= wb_valE;
      end
      if (push_m) begin
        q_addr_q[m_slot] <= wb_dstM;
        q_data_q[m_slot] <= wb_valM;
      end
    end
  end

`ifdef WB_FORWARD_EN
  logic [PW-1:0] fwd_slot;
  always_comb begin
    fwdA_valid = 1'b0;
    fwdA_data  = '0;
    fwdB_valid = 1'b0;
    fwdB_data  = '0;
    fwd_slot   = rd_ptr_q;
    // Oldest to youngest, so the last match (youngest entry) wins.
    for (int i = 0; i < QDEPTH; i++) begin
      if (i < int'(count_q)) begin
        if (rd_srcA != NONE && q_addr_q[fwd_slot] == rd_srcA) begin
          fwdA_valid = 1'b1;
          fwdA_data  = q_data_q[fwd_slot];
        end
        if (rd_srcB != NONE && q_addr_q[fwd_slot] == rd_srcB) begin
          fwdB_valid = 1'b1;
          fwdB_data  = q_data_q[fwd_slot];
        end
      end
      fwd_slot = ptr_inc(fwd_slot);
    end
  end
  assign hazA = baseA && !fwdA_valid;
  assign hazB = baseB && !fwdB_valid;
`else
  assign hazA = baseA;
  assign hazB = baseB;
`endif
endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Randomised and directed bench for regfile_wb_sequencer: a queue-level reference model
// feeds an expected-write scoreboard that a negedge monitor drains.
module tb_regfile_wb_sequencer;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 64;
  localparam int QDEPTH = 4;
  localparam logic [ADDR_W-1:0] NONE = 4'hF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wb_valid = 1'b0, wb_halt = 1'b0;
  logic [ADDR_W-1:0] wb_dstE = NONE, wb_dstM = NONE, rd_srcA = NONE, rd_srcB = NONE;
  logic [DATA_W-1:0] wb_valE = '0, wb_valM = '0;
  logic wb_ready, rf_we, hazA, hazB, halted;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [1:0] dbg_state;
`ifdef WB_FORWARD_EN
  logic fwdA_valid, fwdB_valid;
  logic [DATA_W-1:0] fwdA_data, fwdB_data;
`endif

  regfile_wb_sequencer dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_halt(wb_halt),
    .wb_dstE(wb_dstE), .wb_valE(wb_valE), .wb_dstM(wb_dstM), .wb_valM(wb_valM),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_srcA(rd_srcA), .rd_srcB(rd_srcB), .hazA(hazA), .hazB(hazB),
`ifdef WB_FORWARD_EN
    .fwdA_valid(fwdA_valid), .fwdA_data(fwdA_data), .fwdB_valid(fwdB_valid), .fwdB_data(fwdB_data),
`endif
    .halted(halted), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  bit src_rand = 1'b1;
  int we_after_rst = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: pending writes as a plain queue, drain/halt as a small state number
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] pend[$];
  int m_state = 0;  // 0 run, 1 drain, 2 halt
  bit m_acc = 1'b0, m_we = 1'b0;

  function automatic bit m_ready();
    return (m_state == 0) && ((QDEPTH - pend.size()) >= 2);
  endfunction

  function automatic bit exp_haz(input logic [ADDR_W-1:0] s);
`ifdef WB_FORWARD_EN
    return 1'b0;
`else
    if (s == NONE) return 1'b0;
    foreach (pend[i]) if (pend[i] == s) return 1'b1;
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    m_acc = 1'b0;
    m_we  = 1'b0;
    if (rst) begin
      pend.delete();
      exp_q.delete();
      m_state = 0;
    end else begin
      m_acc = wb_valid && m_ready();
      if (pend.size() > 0) begin
        void'(pend.pop_front());
        m_we = 1'b1;
      end
      if (m_state == 1 && pend.size() == 0) m_state = 2;
      if (m_acc) begin
        if (wb_halt) m_state = 1;
        else begin
          if (wb_dstE != NONE) begin pend.push_back(wb_dstE); exp_q.push_back({wb_dstE, wb_valE}); end
          if (wb_dstM != NONE) begin pend.push_back(wb_dstM); exp_q.push_back({wb_dstM, wb_valM}); end
        end
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    if (mon_en) begin
      logic [ADDR_W+DATA_W-1:0] e;
      if (rf_we) we_after_rst++;
      check("wb_ready", 64'(wb_ready), 64'(m_ready()));
      check("rf_we", 64'(rf_we), 64'(m_we));
      if (rf_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL write_unexpected: got write %0h=%0h, expected none", rf_waddr, rf_wdata);
        end else begin
          e = exp_q.pop_front();
          check("rf_waddr", 64'(rf_waddr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
          check("rf_wdata", rf_wdata, e[DATA_W-1:0]);
        end
      end
      check("hazA", 64'(hazA), 64'(exp_haz(rd_srcA)));
      check("hazB", 64'(hazB), 64'(exp_haz(rd_srcB)));
      check("halted", 64'(halted), 64'(m_state == 2));
    end
  end

  always @(posedge clk) begin
    #1;
    if (src_rand) begin
      rd_srcA = 4'($urandom_range(0, 15));
      rd_srcB = 4'($urandom_range(0, 15));
    end
  end

  // driver tasks
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    wb_valid = 1'b0;
    wb_halt = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    mon_en = 1'b1;
    rst = 1'b0;
  endtask

  task automatic send_req(input bit h, input logic [3:0] de, input logic [63:0] ve,
                          input logic [3:0] dm, input logic [63:0] vm);
    wb_valid = 1'b1;
    wb_halt = h;
    wb_dstE = de; wb_valE = ve;
    wb_dstM = dm; wb_valM = vm;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (m_acc) begin
        wb_valid = 1'b0;
        wb_halt = 1'b0;
        return;
      end
    end
    wb_valid = 1'b0;
    check("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle(input int cycles);
    wb_valid = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  function automatic logic [3:0] rnd_dst();
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    @(posedge clk);
    do_reset(3);
    check("reset_waddr", 64'(rf_waddr), 64'(NONE));
    check("reset_wdata", rf_wdata, 64'(0));
    check("reset_ready", 64'(wb_ready), 64'(1));

    // dual write with hazard timing on r3
    src_rand = 1'b0;
    @(posedge clk); #1;
    rd_srcA = 4'd3; rd_srcB = 4'd4;
    send_req(1'b0, 4'd4, 64'h100, 4'd3, 64'hAB);
    check("dual_haz_N", 64'(hazA), 64'(1));
    @(posedge clk); #1;
    check("dual_w1_addr", 64'(rf_waddr), 64'(4));
    check("dual_w1_data", rf_wdata, 64'h100);
    check("dual_haz_N1", 64'(hazA), 64'(1));
    @(posedge clk); #1;
    check("dual_w2_addr", 64'(rf_waddr), 64'(3));
    check("dual_w2_data", rf_wdata, 64'hAB);
    check("dual_haz_N2", 64'(hazA), 64'(0));
    idle(2);

    // same destination: valM must be the surviving value
    send_req(1'b0, 4'd4, 64'h1F8, 4'd4, 64'h55);
    @(posedge clk); #1;
    check("same_w1_data", rf_wdata, 64'h1F8);
    @(posedge clk); #1;
    check("same_w2_addr", 64'(rf_waddr), 64'(4));
    check("same_w2_data", rf_wdata, 64'h55);
    src_rand = 1'b1;
    idle(2);

    // back-pressure: back-to-back dual writes
    for (int i = 0; i < 3; i++)
      send_req(1'b0, 4'(i), {$urandom, $urandom}, 4'(i + 8), {$urandom, $urandom});
    idle(8);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      logic [3:0] de, dm;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      de = rnd_dst();
      dm = ($urandom_range(0, 5) == 0) ? de : rnd_dst();
      send_req(1'b0, de, {$urandom, $urandom}, dm, {$urandom, $urandom});
    end
    idle(8);

    // halt with writes still queued; dst fields must be ignored
    send_req(1'b0, 4'd1, 64'h11, 4'd2, 64'h22);
    send_req(1'b0, 4'd5, 64'h55, 4'd6, 64'h66);
    send_req(1'b1, 4'd7, 64'h77, 4'd8, 64'h88);
    check("halt_ready_low", 64'(wb_ready), 64'(0));
    for (int i = 0; i < 20 && !halted; i++) begin @(posedge clk); #1; end
    check("halt_reached", 64'(halted), 64'(1));
    wb_valid = 1'b1; wb_dstE = 4'd9; wb_dstM = 4'd10;
    repeat (10) begin @(posedge clk); #1; end
    wb_valid = 1'b0;

    // reset with writes queued: nothing may issue afterwards
    do_reset(2);
    send_req(1'b0, 4'd2, 64'h202, 4'd3, 64'h303);
    send_req(1'b0, 4'd4, 64'h404, 4'd5, 64'h505);
    rst = 1'b1;
    @(posedge clk); #1;
    we_after_rst = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(10);
    check("no_write_after_rst", 64'(we_after_rst), 64'(0));
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
